// File: rtl/batalha_pkg.sv
// Shared definitions for the batalha game: code width, controller state
// encoding and small code helpers.
package batalha_pkg;

  localparam int unsigned CODE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_DONE_P1 = 2'd2,
    ST_DONE_P2 = 2'd3
  } state_e;

  // A code is unusable when all bits are equal (000 or 111).
  function automatic logic code_invalid(input logic [CODE_W-1:0] code);
    return (code == {CODE_W{1'b0}}) || (code == {CODE_W{1'b1}});
  endfunction

  // Rotate left by one: {a,b,c} -> {b,c,a}.
  function automatic logic [CODE_W-1:0] rotl1(input logic [CODE_W-1:0] code);
    return {code[CODE_W-2:0], code[CODE_W-1]};
  endfunction

endpackage

// File: rtl/batalha.sv
// batalha comparator (combinational).
//   p1_a/b/c : secret bits {a,b,c}
//   p2_a/b/c : guess bits  {a,b,c}
//   s1       : secret is invalid (all bits equal)
//   s2       : guess equals the secret rotated left by one
module batalha (
  input  logic p1_a,
  input  logic p1_b,
  input  logic p1_c,
  input  logic p2_a,
  input  logic p2_b,
  input  logic p2_c,
  output logic s1,
  output logic s2
);

  assign s1 = (p1_a & p1_b & p1_c) | (~p1_a & ~p1_b & ~p1_c);

  assign s2 = ~(p2_a ^ p1_b) & ~(p2_b ^ p1_c) & ~(p2_c ^ p1_a);

endmodule

// File: rtl/batalha_ctrl.sv
// Round sequencer for the batalha code-guessing game.
//   clk, rst          : clock, synchronous active-high reset
//   p1_valid/p1_code  : secret submission (acted on in IDLE)
//   p2_valid/p2_code  : guess submission (acted on in ARMED)
//   next              : acknowledge result, start a new round
//   p1_ready/p2_ready : state indicators (IDLE / ARMED)
//   tries_left        : guesses remaining in the round
//   reject/hit/miss   : one-cycle event pulses
//   p1_win/p2_win     : round result levels
//   score1/score2     : saturating round-win counters
module batalha_ctrl
  import batalha_pkg::*;
#(
  parameter int unsigned MAX_TRIES = 4,
  parameter int unsigned SCORE_W   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             p1_valid,
  input  logic [2:0]                       p1_code,
  input  logic                             p2_valid,
  input  logic [2:0]                       p2_code,
  input  logic                             next,
  output logic                             p1_ready,
  output logic                             p2_ready,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
  output logic                             reject,
  output logic                             hit,
  output logic                             miss,
  output logic                             p1_win,
  output logic                             p2_win,
  output logic [SCORE_W-1:0]               score1,
  output logic [SCORE_W-1:0]               score2
);

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_ARMED   = ST_ARMED;
  localparam logic [1:0] S_DONE_P1 = ST_DONE_P1;
  localparam logic [1:0] S_DONE_P2 = ST_DONE_P2;

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  logic [1:0]         state, state_n;
  logic [CODE_W-1:0]  secret, secret_n;
  logic [TRY_W-1:0]   tries_n;
  logic [SCORE_W-1:0] score1_n, score2_n;
  logic               p1_ready_n, p2_ready_n;
  logic               reject_n, hit_n, miss_n;
  logic               p1_win_n, p2_win_n;

  logic [CODE_W-1:0]  cmp_code;
  logic               cmp_invalid, cmp_match;

  // In IDLE the comparator judges the incoming code; afterwards the held secret.
  assign cmp_code = (state == S_IDLE) ? p1_code : secret;

  batalha u_batalha (
    .p1_a (cmp_code[2]),
    .p1_b (cmp_code[1]),
    .p1_c (cmp_code[0]),
    .p2_a (p2_code[2]),
    .p2_b (p2_code[1]),
    .p2_c (p2_code[0]),
    .s1   (cmp_invalid),
    .s2   (cmp_match)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      secret     <= '0;
      tries_left <= '0;
      score1     <= '0;
      score2     <= '0;
      p1_ready   <= 1'b1;
      p2_ready   <= 1'b0;
      reject     <= 1'b0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      p1_win     <= 1'b0;
      p2_win     <= 1'b0;
    end else begin
      state      <= state_n;
      secret     <= secret_n;
      tries_left <= tries_n;
      score1     <= score1_n;
      score2     <= score2_n;
      p1_ready   <= p1_ready_n;
      p2_ready   <= p2_ready_n;
      reject     <= reject_n;
      hit        <= hit_n;
      miss       <= miss_n;
      p1_win     <= p1_win_n;
      p2_win     <= p2_win_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state;
    secret_n = secret;
    tries_n  = tries_left;
    score1_n = score1;
    score2_n = score2;
    reject_n = 1'b0;
    hit_n    = 1'b0;
    miss_n   = 1'b0;

    case (state)
      S_IDLE: begin
        if (p1_valid) begin
          if (cmp_invalid) begin
            reject_n = 1'b1;
          end else begin
            secret_n = p1_code;
            tries_n  = TRY_W'(MAX_TRIES);
            state_n  = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (p2_valid) begin
          if (cmp_match) begin
            hit_n   = 1'b1;
            state_n = S_DONE_P2;
            if (score2 != SCORE_MAX) score2_n = score2 + SCORE_W'(1);
          end else begin
            miss_n  = 1'b1;
            tries_n = tries_left - TRY_W'(1);
            // Last guess used up: player 1 takes the round.
            if (tries_left == TRY_W'(1)) begin
              state_n = S_DONE_P1;
              if (score1 != SCORE_MAX) score1_n = score1 + SCORE_W'(1);
            end
          end
        end
      end
      S_DONE_P1, S_DONE_P2: begin
        if (next) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    p1_ready_n = (state_n == S_IDLE);
    p2_ready_n = (state_n == S_ARMED);
    p1_win_n   = (state_n == S_DONE_P1);
    p2_win_n   = (state_n == S_DONE_P2);
  end

endmodule

// File: tb/tb_batalha_ctrl.sv
// Self-checking bench for batalha_ctrl: a vector table on the default
// configuration plus hand sequences on a SCORE_W=2, MAX_TRIES=1 instance.
module tb_batalha_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance (MAX_TRIES=4, SCORE_W=4)
  logic       rst, p1_valid, p2_valid, next;
  logic [2:0] p1_code, p2_code;
  logic       p1_ready, p2_ready, reject, hit, miss, p1_win, p2_win;
  logic [2:0] tries_left;
  logic [3:0] score1, score2;

  batalha_ctrl dut (
    .clk(clk), .rst(rst),
    .p1_valid(p1_valid), .p1_code(p1_code),
    .p2_valid(p2_valid), .p2_code(p2_code),
    .next(next),
    .p1_ready(p1_ready), .p2_ready(p2_ready), .tries_left(tries_left),
    .reject(reject), .hit(hit), .miss(miss),
    .p1_win(p1_win), .p2_win(p2_win),
    .score1(score1), .score2(score2)
  );

  // Small instance for saturation and single-try rounds
  logic       rst2, p1_valid2, p2_valid2, next2;
  logic [2:0] p1_code2, p2_code2;
  logic       p1_ready2, p2_ready2, reject2, hit2, miss2, p1_win2, p2_win2;
  logic [0:0] tries_left2;
  logic [1:0] score1_2, score2_2;

  batalha_ctrl #(.MAX_TRIES(1), .SCORE_W(2)) dut2 (
    .clk(clk), .rst(rst2),
    .p1_valid(p1_valid2), .p1_code(p1_code2),
    .p2_valid(p2_valid2), .p2_code(p2_code2),
    .next(next2),
    .p1_ready(p1_ready2), .p2_ready(p2_ready2), .tries_left(tries_left2),
    .reject(reject2), .hit(hit2), .miss(miss2),
    .p1_win(p1_win2), .p2_win(p2_win2),
    .score1(score1_2), .score2(score2_2)
  );

  typedef struct {
    logic       rst;
    logic       p1v;
    logic [2:0] p1c;
    logic       p2v;
    logic [2:0] p2c;
    logic       nxt;
    logic       p1r;
    logic       p2r;
    logic [2:0] tl;
    logic       rej;
    logic       hit;
    logic       miss;
    logic       w1;
    logic       w2;
    logic [3:0] s1;
    logic [3:0] s2;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(int r, int p1v, int p1c, int p2v, int p2c, int nx,
                              int p1r, int p2r, int tl, int rej, int h, int m,
                              int w1, int w2, int s1, int s2);
    vec_t v;
    v.rst = 1'(r);     v.p1v = 1'(p1v);  v.p1c = 3'(p1c);
    v.p2v = 1'(p2v);   v.p2c = 3'(p2c);  v.nxt = 1'(nx);
    v.p1r = 1'(p1r);   v.p2r = 1'(p2r);  v.tl  = 3'(tl);
    v.rej = 1'(rej);   v.hit = 1'(h);    v.miss = 1'(m);
    v.w1  = 1'(w1);    v.w2  = 1'(w2);
    v.s1  = 4'(s1);    v.s2  = 4'(s2);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; p1_valid = 1'b0; p2_valid = 1'b0; next = 1'b0;
    p1_code = '0; p2_code = '0;
    rst2 = 1'b1; p1_valid2 = 1'b0; p2_valid2 = 1'b0; next2 = 1'b0;
    p1_code2 = '0; p2_code2 = '0;

    //            rst p1v p1c    p2v p2c    nx  p1r p2r tl rej hit miss w1 w2 s1 s2
    vecs.push_back(mk(1, 0, 3'b000, 0, 3'b000, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // reset
    vecs.push_back(mk(0, 1, 3'b110, 1, 3'b101, 0,  0, 1, 4, 0, 0, 0, 0, 0, 0, 0)); // arm; same-edge guess ignored
    vecs.push_back(mk(0, 0, 3'b000, 1, 3'b101, 0,  0, 0, 4, 0, 1, 0, 0, 1, 0, 1)); // hit
    vecs.push_back(mk(0, 1, 3'b011, 1, 3'b101, 0,  0, 0, 4, 0, 0, 0, 0, 1, 0, 1)); // DONE_P2 ignores both
    vecs.push_back(mk(0, 0, 3'b000, 0, 3'b000, 0,  0, 0, 4, 0, 0, 0, 0, 1, 0, 1)); // hold
    vecs.push_back(mk(0, 1, 3'b011, 0, 3'b000, 1,  1, 0, 4, 0, 0, 0, 0, 0, 0, 1)); // next; p1 ignored
    vecs.push_back(mk(0, 1, 3'b000, 0, 3'b000, 0,  1, 0, 4, 1, 0, 0, 0, 0, 0, 1)); // reject 000
    vecs.push_back(mk(0, 1, 3'b111, 0, 3'b000, 0,  1, 0, 4, 1, 0, 0, 0, 0, 0, 1)); // reject 111
    vecs.push_back(mk(0, 0, 3'b111, 0, 3'b000, 0,  1, 0, 4, 0, 0, 0, 0, 0, 0, 1)); // code without valid
    vecs.push_back(mk(0, 1, 3'b011, 0, 3'b000, 0,  0, 1, 4, 0, 0, 0, 0, 0, 0, 1)); // arm 011
    vecs.push_back(mk(0, 0, 3'b000, 1, 3'b000, 0,  0, 1, 3, 0, 0, 1, 0, 0, 0, 1)); // miss
    vecs.push_back(mk(0, 1, 3'b101, 1, 3'b111, 0,  0, 1, 2, 0, 0, 1, 0, 0, 0, 1)); // miss; p1 ignored
    vecs.push_back(mk(0, 0, 3'b000, 1, 3'b011, 0,  0, 1, 1, 0, 0, 1, 0, 0, 0, 1)); // miss
    vecs.push_back(mk(0, 0, 3'b000, 1, 3'b010, 0,  0, 0, 0, 0, 0, 1, 1, 0, 1, 1)); // last miss -> P1
    vecs.push_back(mk(0, 0, 3'b000, 1, 3'b110, 0,  0, 0, 0, 0, 0, 0, 1, 0, 1, 1)); // match in DONE_P1 ignored
    vecs.push_back(mk(0, 0, 3'b000, 0, 3'b000, 1,  1, 0, 0, 0, 0, 0, 0, 0, 1, 1)); // next
    vecs.push_back(mk(0, 1, 3'b100, 0, 3'b000, 0,  0, 1, 4, 0, 0, 0, 0, 0, 1, 1)); // arm 100
    vecs.push_back(mk(0, 0, 3'b000, 1, 3'b100, 0,  0, 1, 3, 0, 0, 1, 0, 0, 1, 1)); // miss
    vecs.push_back(mk(0, 0, 3'b000, 1, 3'b001, 0,  0, 0, 3, 0, 1, 0, 0, 1, 1, 2)); // hit
    vecs.push_back(mk(0, 0, 3'b000, 0, 3'b000, 1,  1, 0, 3, 0, 0, 0, 0, 0, 1, 2)); // next
    vecs.push_back(mk(0, 0, 3'b000, 1, 3'b101, 1,  1, 0, 3, 0, 0, 0, 0, 0, 1, 2)); // next/p2 in IDLE ignored
    vecs.push_back(mk(0, 1, 3'b101, 0, 3'b000, 0,  0, 1, 4, 0, 0, 0, 0, 0, 1, 2)); // arm 101
    vecs.push_back(mk(0, 0, 3'b000, 1, 3'b011, 0,  0, 0, 4, 0, 1, 0, 0, 1, 1, 3)); // first-guess hit
    vecs.push_back(mk(0, 0, 3'b000, 0, 3'b000, 1,  1, 0, 4, 0, 0, 0, 0, 0, 1, 3)); // next
    vecs.push_back(mk(0, 1, 3'b010, 0, 3'b000, 0,  0, 1, 4, 0, 0, 0, 0, 0, 1, 3)); // arm 010
    vecs.push_back(mk(1, 0, 3'b000, 1, 3'b100, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // reset beats hit
    vecs.push_back(mk(0, 1, 3'b001, 0, 3'b000, 0,  0, 1, 4, 0, 0, 0, 0, 0, 0, 0)); // arm 001
    vecs.push_back(mk(0, 0, 3'b000, 0, 3'b010, 0,  0, 1, 4, 0, 0, 0, 0, 0, 0, 0)); // matching code, no valid
    vecs.push_back(mk(0, 0, 3'b000, 1, 3'b010, 0,  0, 0, 4, 0, 1, 0, 0, 1, 0, 1)); // hit

    foreach (vecs[i]) begin
      rst      = vecs[i].rst;
      p1_valid = vecs[i].p1v;
      p1_code  = vecs[i].p1c;
      p2_valid = vecs[i].p2v;
      p2_code  = vecs[i].p2c;
      next     = vecs[i].nxt;
      tick();
      chk("p1_ready",   i, 8'(p1_ready),   8'(vecs[i].p1r));
      chk("p2_ready",   i, 8'(p2_ready),   8'(vecs[i].p2r));
      chk("tries_left", i, 8'(tries_left), 8'(vecs[i].tl));
      chk("reject",     i, 8'(reject),     8'(vecs[i].rej));
      chk("hit",        i, 8'(hit),        8'(vecs[i].hit));
      chk("miss",       i, 8'(miss),       8'(vecs[i].miss));
      chk("p1_win",     i, 8'(p1_win),     8'(vecs[i].w1));
      chk("p2_win",     i, 8'(p2_win),     8'(vecs[i].w2));
      chk("score1",     i, 8'(score1),     8'(vecs[i].s1));
      chk("score2",     i, 8'(score2),     8'(vecs[i].s2));
    end
    rst = 1'b0; p1_valid = 1'b0; p2_valid = 1'b0; next = 1'b0;

    // Second instance: saturation with SCORE_W=2, single-try rounds.
    rst2 = 1'b1;
    tick();
    chk("d2 reset p1_ready", 100, 8'(p1_ready2), 8'd1);
    chk("d2 reset score2",   100, 8'(score2_2),  8'd0);
    rst2 = 1'b0;

    for (int k = 1; k <= 4; k++) begin
      p1_valid2 = 1'b1; p1_code2 = 3'b110;
      tick();
      p1_valid2 = 1'b0;
      chk("d2 armed p2_ready", 100 + k, 8'(p2_ready2),   8'd1);
      chk("d2 armed tries",    100 + k, 8'(tries_left2), 8'd1);
      p2_valid2 = 1'b1; p2_code2 = 3'b101;
      tick();
      p2_valid2 = 1'b0;
      chk("d2 hit",    100 + k, 8'(hit2),     8'd1);
      chk("d2 score2", 100 + k, 8'(score2_2), 8'((k < 3) ? k : 3));
      next2 = 1'b1;
      tick();
      next2 = 1'b0;
      chk("d2 idle p1_ready", 100 + k, 8'(p1_ready2), 8'd1);
    end

    // One miss with MAX_TRIES=1 ends the round for player 1.
    p1_valid2 = 1'b1; p1_code2 = 3'b110;
    tick();
    p1_valid2 = 1'b0;
    p2_valid2 = 1'b1; p2_code2 = 3'b000;
    tick();
    p2_valid2 = 1'b0;
    chk("d2 miss",   110, 8'(miss2),       8'd1);
    chk("d2 p1_win", 110, 8'(p1_win2),     8'd1);
    chk("d2 tries",  110, 8'(tries_left2), 8'd0);
    chk("d2 score1", 110, 8'(score1_2),    8'd1);
    next2 = 1'b1;
    tick();
    next2 = 1'b0;

    // Reset in the middle of an armed round.
    p1_valid2 = 1'b1; p1_code2 = 3'b110;
    tick();
    p1_valid2 = 1'b0;
    chk("d2 rearm p2_ready", 111, 8'(p2_ready2), 8'd1);
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    chk("d2 rst p1_ready", 112, 8'(p1_ready2),   8'd1);
    chk("d2 rst p2_ready", 112, 8'(p2_ready2),   8'd0);
    chk("d2 rst tries",    112, 8'(tries_left2), 8'd0);
    chk("d2 rst score1",   112, 8'(score1_2),    8'd0);
    chk("d2 rst score2",   112, 8'(score2_2),    8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
